tof_bram_rd_arbiter: RTL
========================

TOF_BRAM_RD_ARBITER -- requirements
Module: tof_bram_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of read requesters (2..4).
REQ-002 SHALL have parameter ADDR_W, default 9, BRAM port-B address width ({sensor[2:0], zone[5:0]}).
REQ-003 SHALL have parameter DATA_W, default 16, BRAM data width.
REQ-004 SHALL have parameter RD_LAT, default 1, BRAM address-to-data latency in cycles (1..3).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have frame_valid  in  1  BRAM holds a complete frame (all_data_written level).
REQ-007 SHALL have req  in  NUM_REQ  per-requester burst request, level.
REQ-008 SHALL have req_sensor  in  3*NUM_REQ  per-requester sensor index, 3 bits per slot.
REQ-009 SHALL have addrb  out  ADDR_W  BRAM port-B read address.
REQ-010 SHALL have doutb  in  DATA_W  BRAM port-B read data.
REQ-011 SHALL have gnt  out  NUM_REQ  one-hot grant, held for the whole burst.
REQ-012 SHALL have data_out  out  DATA_W, data_valid  out  1, data_zone  out  6, data_last  out  1: registered read stream to the granted requester.
REQ-013 SHALL have busy  out  1  high from grant until the burst completes.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE.
REQ-015 IDLE: when frame_valid=1 and |req=1, SHALL latch the winner's req_sensor, set gnt one-hot and busy=1 at the next edge, and enter ISSUE with zone counter 0.
REQ-016 Arbitration SHALL be round-robin: search starts at rr_ptr; after every completed burst rr_ptr = winner+1 mod NUM_REQ.
REQ-017 ISSUE: addrb={sensor, zone} SHALL be driven for zones 0..63 on 64 consecutive cycles, one address per cycle, with no gaps.
REQ-018 After zone 63 is issued, SHALL enter DRAIN and stay there until the last data word has been presented.
REQ-019 data_valid SHALL go high exactly RD_LAT+1 cycles after the corresponding address is driven, with data_out=doutb captured and data_zone equal to that address's zone.
REQ-020 data_valid SHALL be high for exactly 64 consecutive cycles per burst; data_last SHALL be high with the zone-63 word only.
REQ-021 gnt and busy SHALL clear on the cycle after data_last; the FSM SHALL be in IDLE that cycle, and the earliest next grant is one cycle later.
REQ-022 A burst, once granted, SHALL run to completion regardless of req or frame_valid changes.
REQ-023 req deasserted before grant SHALL lose the request with no residual state.
REQ-024 Simultaneous requests SHALL resolve by rr_ptr order only; no requester SHALL wait more than NUM_REQ-1 bursts.
REQ-025 frame_valid=0 in IDLE SHALL block all grants.
REQ-026 In IDLE, addrb SHALL hold its last value and data_valid SHALL be 0.
REQ-027 Zone counter SHALL be 6 bits and SHALL NOT wrap within a burst; sensor bits SHALL never change mid-burst.

Reset
REQ-028 On reset=1 at a clk edge: state=IDLE, gnt=0, busy=0, addrb=0, data_out=0, data_valid=0, data_zone=0, data_last=0, rr_ptr=0, zone counter=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst at that edge, with no further data_valid; in-flight BRAM words SHALL be discarded.

Verification
REQ-030 Single request: frame_valid=1, req=01, req_sensor[2:0]=5, RD_LAT=1 -> gnt=01, addrb 0x140..0x17F on 64 cycles, data_valid begins 2 cycles after 0x140, data_last at zone 63, gnt=00 the next cycle.
REQ-031 Contention: req=11 held continuously, rr_ptr=0 -> grant order 01,10,01,10; each burst delivers 64 words; a one-cycle gap sits between bursts.
REQ-032 Gating: req=01, frame_valid=0 for 10 cycles then 1 -> no gnt during the 10 cycles; gnt=01 one edge after frame_valid rises.
REQ-033 Req drop mid-burst: req=01 granted, req=00 at zone 20 -> the burst still completes 64 words, data_last asserts, then IDLE.
REQ-034 Reset mid-burst: reset=1 at zone 30 -> the next cycle has gnt=0, data_valid=0, busy=0, rr_ptr=0; a fresh req=10 is granted after reset is released.
REQ-035 Latency sweep: RD_LAT=3 with BRAM model returning {addrb} -> data_out equals {sensor,zone} and data_zone matches on every valid cycle.

Source files
------------

// File: rtl/tof_bram_rd_arbiter.sv
// Round-robin burst arbiter for the ToF frame BRAM read port.
// Each grant streams all 64 zones of one sensor to the winning requester.
module tof_bram_rd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_valid,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_sensor,
  output logic [ADDR_W-1:0]      addrb,
  input  logic [DATA_W-1:0]      doutb,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [DATA_W-1:0]      data_out,
  output logic                   data_valid,
  output logic [5:0]             data_zone,
  output logic                   data_last,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_addr;
  logic [5:0]          r_zone;
  logic [2:0]          r_sens;
  logic [IW-1:0]       r_rr;
  logic [IW-1:0]       r_win;
  logic [DATA_W-1:0]   r_dout;
  logic                r_dv;
  logic [5:0]          r_dz;
  logic                r_last;

  logic                w_found;
  logic [IW-1:0]       w_win;
  logic [2:0]          w_sens;
  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic                w_grant;
  logic                w_issue;
  logic [IW-1:0]       w_rr_n;

  logic                r_pv [1:RD_LAT];
  logic [5:0]          r_pz [1:RD_LAT];

  // First pass covers rr_ptr..top, second pass wraps to 0..rr_ptr-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sens  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i] && (IW'(i) >= r_rr)) begin
        w_found = 1'b1;
        w_win   = IW'(i);
        w_sens  = req_sensor[3*i +: 3];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_found = 1'b1;
        w_win   = IW'(i);
        w_sens  = req_sensor[3*i +: 3];
      end
    end
  end

  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i] = (IW'(i) == w_win);
    end
  end

  assign w_grant = (r_state == S_IDLE) && frame_valid && w_found;
  assign w_issue = (r_state == S_ISSUE);
  assign w_rr_n  = (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + IW'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_grant)          w_state_n = S_ISSUE;
      S_ISSUE: if (r_zone == 6'd63)  w_state_n = S_DRAIN;
      S_DRAIN: if (r_last)           w_state_n = S_IDLE;
      default:                       w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt  <= '0;
      r_busy <= 1'b0;
      r_addr <= '0;
      r_zone <= '0;
      r_sens <= '0;
      r_rr   <= '0;
      r_win  <= '0;
    end else if (w_grant) begin
      r_gnt  <= w_gnt_oh;
      r_busy <= 1'b1;
      r_win  <= w_win;
      r_sens <= w_sens;
      r_zone <= '0;
      r_addr <= ADDR_W'({w_sens, 6'd0});
    end else if (w_issue && (r_zone != 6'd63)) begin
      r_zone <= r_zone + 6'd1;
      r_addr <= ADDR_W'({r_sens, r_zone + 6'd1});
    end else if ((r_state == S_DRAIN) && r_last) begin
      r_gnt  <= '0;
      r_busy <= 1'b0;
      r_rr   <= w_rr_n;
    end
  end

  // Zone tag follows each address through the BRAM read latency.
  for (genvar g = 1; g <= RD_LAT; g++) begin : g_pipe
    if (g == 1) begin : g_head
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pv[g] <= 1'b0;
          r_pz[g] <= '0;
        end else begin
          r_pv[g] <= w_issue;
          r_pz[g] <= r_zone;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pv[g] <= 1'b0;
          r_pz[g] <= '0;
        end else begin
          r_pv[g] <= r_pv[g-1];
          r_pz[g] <= r_pz[g-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
      r_dv   <= 1'b0;
      r_dz   <= '0;
      r_last <= 1'b0;
    end else begin
      r_dv   <= r_pv[RD_LAT];
      r_last <= r_pv[RD_LAT] && (r_pz[RD_LAT] == 6'd63);
      if (r_pv[RD_LAT]) begin
        r_dout <= doutb;
        r_dz   <= r_pz[RD_LAT];
      end
    end
  end

  assign addrb      = r_addr;
  assign gnt        = r_gnt;
  assign busy       = r_busy;
  assign data_out   = r_dout;
  assign data_valid = r_dv;
  assign data_zone  = r_dz;
  assign data_last  = r_last;

endmodule
